// File: rtl/random_gen_pkg.sv
// random_pkg: shared state encoding, Galois LFSR step function and default tap masks.
package random_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HOLD, FREE} state_t;
  localparam logic [7:0]  TAPS8  = 8'h1D;
  localparam logic [15:0] TAPS16 = 16'h002D;
  localparam logic [31:0] TAPS32 = 32'h000000C5;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] taps, input int w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ({s[30:0], 1'b0} ^ (s[5'(w - 1)] ? taps : 32'd0)) & m;
  endfunction
endpackage

// File: rtl/random_gen_if.sv
// random_gen_if: control, seed and word handshake between the generator and its consumer.
interface random_gen_if #(parameter int WIDTH = 8, parameter int OUT_W = 4) ();
  logic             mode_in;
  logic             seed_load_in;
  logic [WIDTH-1:0] seed_in;
  logic             req_in;
  logic             ready_in;
  logic [OUT_W-1:0] rnd_out;
  logic             valid_out;
  logic             busy_out;
  modport master (output mode_in, seed_load_in, seed_in, req_in, ready_in, input rnd_out, valid_out, busy_out);
  modport slave  (input mode_in, seed_load_in, seed_in, req_in, ready_in, output rnd_out, valid_out, busy_out);
endinterface

// File: rtl/random_gen_lfsr_core.sv
// lfsr_core: Galois LFSR register with step enable and a load that never admits the all-zero state.
module lfsr_core import random_pkg::*; #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nq
);
  assign nq = WIDTH'(lfsr_next(32'(q), 32'(TAPS), WIDTH));
  always_ff @(posedge clk_in)
    if (!reset_n_in) q <= SEED;
    else if (load) q <= (load_val == '0) ? SEED : load_val;
    else if (step) q <= nq;
endmodule

// File: rtl/random_gen.sv
// random_gen: LFSR random source with free-run and on-demand handshake modes.
module random_gen import random_pkg::*; #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               OUT_W = 4,
  parameter int               STEPS = OUT_W
) (
  input logic       clk_in,
  input logic       reset_n_in,
  random_gen_if.slave bus
);
  localparam int             CW    = $clog2(STEPS + 1);
  localparam logic [CW-1:0]  LAST  = CW'(STEPS);
  localparam state_t         START = (STEPS == 1) ? HOLD : RUN;
  if (OUT_W > WIDTH || OUT_W < 1) begin : g_bad_out_w
    $error("random_gen: OUT_W must be in 1..WIDTH");
  end
  if (STEPS < 1) begin : g_bad_steps
    $error("random_gen: STEPS must be >= 1");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("random_gen: SEED must be non-zero");
  end
  if (TAPS[0] != 1'b1) begin : g_bad_taps
    $error("random_gen: TAPS[0] must be 1");
  end
  state_t           state, nxt;
  logic [CW-1:0]    cnt, cnt_nxt, cnt_inc;
  logic             step, cap;
  logic [WIDTH-1:0] q, nq;
  logic [OUT_W-1:0] rnd;
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED)) u_core (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .load(bus.seed_load_in),
    .load_val(bus.seed_in), .step(step), .q(q), .nq(nq)
  );
  assign cnt_inc = cnt + CW'(1);
  // cap marks edges where the freshly stepped state becomes the visible word
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    step    = 1'b0;
    cap     = 1'b0;
    unique case (state)
      IDLE: if (bus.mode_in) begin
        nxt  = FREE;
        step = 1'b1;
        cap  = 1'b1;
      end else if (bus.req_in) begin
        nxt     = START;
        step    = 1'b1;
        cnt_nxt = CW'(1);
        cap     = (STEPS == 1);
      end
      RUN: begin
        step    = 1'b1;
        cnt_nxt = cnt_inc;
        if (cnt_inc == LAST) begin
          nxt = HOLD;
          cap = 1'b1;
        end
      end
      HOLD: if (bus.ready_in) begin
        nxt     = bus.req_in ? START : IDLE;
        step    = bus.req_in;
        cnt_nxt = bus.req_in ? CW'(1) : '0;
        cap     = bus.req_in && (STEPS == 1);
      end
      FREE: if (!bus.mode_in) nxt = IDLE;
      else begin
        step = 1'b1;
        cap  = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_in)
    if (!reset_n_in) begin
      state <= IDLE;
      cnt   <= '0;
      rnd   <= '0;
    end else if (bus.seed_load_in) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (cap) rnd <= nq[OUT_W-1:0];
    end
  assign bus.rnd_out   = rnd;
  assign bus.valid_out = (state == HOLD) || (state == FREE);
  assign bus.busy_out  = (state == RUN);
endmodule

// File: tb/tb_random_gen.sv
// tb_random_gen: directed and randomized checks of random_gen against a polynomial-arithmetic model.
module tb_random_gen;
  logic clk_in = 1'b0;
  logic reset_n_in = 1'b0;
  always #5 clk_in = ~clk_in;
  int tests = 0;
  int fails = 0;
  longint ma, mb, mc;
  logic [7:0] exp14 [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                             8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13};
  random_gen_if #(.WIDTH(8),  .OUT_W(4))  a_if ();
  random_gen_if #(.WIDTH(8),  .OUT_W(8))  b_if ();
  random_gen_if #(.WIDTH(16), .OUT_W(16)) c_if ();
  random_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .OUT_W(4), .STEPS(4)) dut_a (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .bus(a_if.slave));
  random_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED(8'h01), .OUT_W(8), .STEPS(8)) dut_b (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .bus(b_if.slave));
  random_gen #(.WIDTH(16), .TAPS(16'h002D), .SEED(16'h0001), .OUT_W(16), .STEPS(1)) dut_c (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .bus(c_if.slave));
  // multiply by x modulo the feedback polynomial x^w + taps
  function automatic longint gf_step(input longint v, input int w, input longint taps);
    longint t;
    t = v * 2;
    if (t >= (longint'(1) << w)) t = t ^ ((longint'(1) << w) | taps);
    return t;
  endfunction
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic a_issue(input logic rdy, output int n);
    a_if.req_in = 1'b1;
    a_if.ready_in = rdy;
    tick;
    a_if.req_in = 1'b0;
    n = 1;
    while (!a_if.valid_out && n < 20) begin
      tick;
      n++;
    end
    repeat (4) ma = gf_step(ma, 8, 'h1D);
  endtask
  task automatic a_word(input int bp, input string tag);
    int n;
    a_issue(bp == 0, n);
    chk({tag, "_lat"}, 64'(n), 64'd4);
    chk({tag, "_rnd"}, 64'(a_if.rnd_out), 64'(ma & 'hF));
    for (int i = 0; i < bp; i++) begin
      tick;
      chk({tag, "_hold"}, {a_if.valid_out, a_if.rnd_out}, {1'b1, 4'(ma)});
    end
    a_if.ready_in = 1'b1;
    tick;
    chk({tag, "_done"}, 64'(a_if.valid_out), 64'd0);
  endtask
  task automatic a_load(input logic [7:0] s);
    a_if.seed_in = s;
    a_if.seed_load_in = 1'b1;
    tick;
    a_if.seed_load_in = 1'b0;
    ma = (s == 0) ? 1 : longint'(s);
  endtask
  initial begin
    int n, steps, zero, bad;
    {a_if.mode_in, a_if.seed_load_in, a_if.seed_in, a_if.req_in, a_if.ready_in} = '0;
    {b_if.mode_in, b_if.seed_load_in, b_if.seed_in, b_if.req_in, b_if.ready_in} = '0;
    {c_if.mode_in, c_if.seed_load_in, c_if.seed_in, c_if.req_in, c_if.ready_in} = '0;
    repeat (2) tick;
    chk("rst_out", {a_if.valid_out, a_if.busy_out, a_if.rnd_out}, 6'd0);
    chk("rst_b", {b_if.valid_out, b_if.busy_out, b_if.rnd_out}, 10'd0);
    reset_n_in = 1'b1;
    ma = 1;
    a_if.req_in = 1'b1;
    a_if.ready_in = 1'b1;
    tick;
    a_if.req_in = 1'b0;
    chk("accept_busy", {a_if.busy_out, a_if.valid_out}, 2'b10);
    n = 1;
    while (!a_if.valid_out && n < 20) begin
      tick;
      n++;
    end
    repeat (4) ma = gf_step(ma, 8, 'h1D);
    chk("w1_lat", 64'(n), 64'd4);
    chk("w1_rnd", 64'(a_if.rnd_out), 64'(ma & 'hF));
    tick;
    a_word(0, "w2");
    a_word(0, "w3");
    a_word(5, "bp");
    a_issue(1'b0, n);
    chk("b2b_first", 64'(a_if.rnd_out), 64'(ma & 'hF));
    a_if.ready_in = 1'b1;
    a_if.req_in = 1'b1;
    tick;
    a_if.req_in = 1'b0;
    chk("b2b_busy", {a_if.busy_out, a_if.valid_out}, 2'b10);
    n = 1;
    while (!a_if.valid_out && n < 20) begin
      tick;
      n++;
    end
    repeat (4) ma = gf_step(ma, 8, 'h1D);
    chk("b2b_lat", 64'(n), 64'd4);
    chk("b2b_rnd", 64'(a_if.rnd_out), 64'(ma & 'hF));
    tick;
    a_load(8'hA5);
    a_word(0, "seedA5");
    a_load(8'h00);
    a_word(0, "seed00");
    a_if.req_in = 1'b1;
    a_if.ready_in = 1'b1;
    tick;
    a_if.req_in = 1'b0;
    tick;
    a_load(8'h3C);
    chk("abort", {a_if.valid_out, a_if.busy_out}, 2'b00);
    tick;
    chk("abort_idle", {a_if.valid_out, a_if.busy_out}, 2'b00);
    a_word(0, "post_abort");
    for (int i = 0; i < 6; i++) begin
      a_load((i == 2) ? 8'h00 : 8'($urandom_range(0, 255)));
      a_word($urandom_range(0, 3), "rand");
    end
    a_issue(1'b0, n);
    chk("pre_rst", 64'(a_if.valid_out), 64'd1);
    reset_n_in = 1'b0;
    a_if.seed_load_in = 1'b1;
    a_if.seed_in = 8'h77;
    tick;
    reset_n_in = 1'b1;
    a_if.seed_load_in = 1'b0;
    ma = 1;
    chk("rst_hold", {a_if.valid_out, a_if.busy_out, a_if.rnd_out}, 6'd0);
    a_issue(1'b0, n);
    chk("glitch_pre", 64'(a_if.rnd_out), 64'(ma & 'hF));
    #2 reset_n_in = 1'b0;
    #2 reset_n_in = 1'b1;
    tick;
    chk("glitch_hold", {a_if.valid_out, a_if.rnd_out}, {1'b1, 4'(ma)});
    a_if.ready_in = 1'b1;
    tick;
    a_word(0, "post_glitch");
    mb = 1;
    b_if.mode_in = 1'b1;
    tick;
    mb = gf_step(mb, 8, 'h1D);
    zero = 0;
    bad = 0;
    for (steps = 1; steps < 300; steps++) begin
      if (steps <= 14) chk("fr8_seq", 64'(b_if.rnd_out), 64'(exp14[steps-1]));
      if (b_if.rnd_out !== 8'(mb) || b_if.valid_out !== 1'b1) bad++;
      if (b_if.rnd_out == 8'h00) zero++;
      if (b_if.rnd_out == 8'h01) break;
      tick;
      mb = gf_step(mb, 8, 'h1D);
    end
    chk("fr8_period", 64'(steps), 64'd255);
    chk("fr8_zero", 64'(zero), 64'd0);
    chk("fr8_model", 64'(bad), 64'd0);
    b_if.mode_in = 1'b0;
    tick;
    chk("fr8_exit", 64'(b_if.valid_out), 64'd0);
    mc = 1;
    c_if.mode_in = 1'b1;
    tick;
    mc = gf_step(mc, 16, 'h2D);
    zero = 0;
    bad = 0;
    for (steps = 1; steps < 70000; steps++) begin
      if (c_if.rnd_out !== 16'(mc)) bad++;
      if (c_if.rnd_out == 16'h0000) zero++;
      if (c_if.rnd_out == 16'h0001) break;
      tick;
      mc = gf_step(mc, 16, 'h2D);
    end
    chk("fr16_period", 64'(steps), 64'd65535);
    chk("fr16_zero", 64'(zero), 64'd0);
    chk("fr16_model", 64'(bad), 64'd0);
    c_if.mode_in = 1'b0;
    tick;
    c_if.req_in = 1'b1;
    c_if.ready_in = 1'b1;
    tick;
    c_if.req_in = 1'b0;
    mc = gf_step(mc, 16, 'h2D);
    chk("s1_valid", {c_if.valid_out, c_if.busy_out}, 2'b10);
    chk("s1_rnd", 64'(c_if.rnd_out), 64'(mc));
    tick;
    chk("s1_done", 64'(c_if.valid_out), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/random_gen.md
Name: random_gen

Overview:
- Parametrised successor to the fixed 8-bit LFSR.
- Galois LFSR with configurable width and taps, run-time seed load, and zero-seed protection.
- Two output modes:
  - free-run: new value every cycle.
  - on-demand: req/valid/ready handshake; each word is produced after a fixed number of decorrelation steps.
- Feeds display/test-pattern logic in the Max10 designs.

Parameters:
- WIDTH, 8, LFSR state width (3..32).
- TAPS, 8'h1D, Galois feedback mask [WIDTH-1:0]. Bit 0 must be 1. Default is x^8+x^4+x^3+x^2+1, maximal length 255.
- SEED, 8'h01, reset state and replacement for an all-zero load. Must be non-zero.
- OUT_W, 4, output word width, 1..WIDTH.
- STEPS, OUT_W, LFSR advances per on-demand word, >=1.

Ports:
- clk_in  input  1  clock, rising edge.
- reset_n_in  input  1  synchronous active-low reset.
- mode_in  input  1  0 = on-demand, 1 = free-run. Sampled only in IDLE.
- seed_load_in  input  1  load seed_in into the LFSR this edge.
- seed_in  input  WIDTH  seed value.
- req_in  input  1  on-demand word request.
- ready_in  input  1  consumer accepts rnd_out.
- rnd_out  output  OUT_W  random word.
- valid_out  output  1  rnd_out valid.
- busy_out  output  1  high in RUN.

Behaviour:
- Step function: next = {lfsr[WIDTH-2:0],1'b0} ^ (lfsr[WIDTH-1] ? TAPS : 0).
- Reset (reset_n_in low at an edge):
  - lfsr=SEED, state=IDLE, step counter=0.
  - valid_out=0, busy_out=0, rnd_out=0.
  - Reset overrides every other input.
- Seed load (priority below reset, above everything else):
  - lfsr = (seed_in==0) ? SEED : seed_in.
  - state forced to IDLE, counter cleared, valid_out drops next cycle.
  - An in-progress or pending word is discarded.
- FSM:
  - IDLE:
    - mode_in=1 -> FREE.
    - Else req_in=1 -> RUN; the first step happens on the accepting edge; counter=1.
    - Else hold; lfsr unchanged.
  - RUN:
    - Step every edge.
    - When counter==STEPS after the step: go to HOLD and register rnd_out = new lfsr[OUT_W-1:0].
    - req_in is ignored in RUN.
  - HOLD:
    - valid_out=1; rnd_out and lfsr are stable.
    - ready_in=1 completes the transfer.
    - On completion: req_in=1 on the same edge -> RUN (back-to-back, first step on that edge); otherwise IDLE.
  - FREE:
    - Step every edge; valid_out=1; rnd_out = current lfsr[OUT_W-1:0], registered, equal to the state.
    - ready_in and req_in are ignored.
    - mode_in=0 -> IDLE; valid_out drops the next cycle.
- Latency: req accepted at edge k -> valid_out high after edge k+STEPS-1, i.e. STEPS cycles from request.
- Output rules: valid_out=1 only in HOLD and FREE. busy_out=1 only in RUN.
- Wrap-around: with maximal taps the state cycles 2^WIDTH-1 values and never reaches zero. The all-zero state is unreachable except via seed, and the seed path is guarded.
- Elaboration checks: OUT_W<=WIDTH, STEPS>=1, SEED!=0, TAPS[0]==1.
- Counter width: $clog2(STEPS+1).

Decomposition:
- Package random_pkg holds:
  - state enum {IDLE, RUN, HOLD, FREE}.
  - lfsr_next(state, taps) function.
  - default taps constants for widths 8/16/32 (8'h1D, 16'h002D, 32'h000000C5).
- One sub-module, lfsr_core:
  - WIDTH/TAPS/SEED register with synchronous active-low reset, step enable, and guarded load.
  - random_gen wraps it with the FSM, counter and output register.

Test Plan:
- Reset, on-demand, defaults (OUT_W=4, STEPS=4):
  - Pulse req_in, ready_in=1 -> valid_out high 4 cycles after acceptance; lfsr=0x10, rnd_out=0x0.
  - Next request -> lfsr=0x1D, rnd_out=0xD.
  - Third request -> lfsr=0xCD, rnd_out=0xD.
- Back-to-back and backpressure:
  - ready_in=0 for 5 cycles in HOLD -> rnd_out and lfsr frozen, valid_out stays 1.
  - ready_in=1 with req_in=1 -> no IDLE cycle, busy_out=1 the next cycle.
- Free-run (OUT_W=8) from reset:
  - rnd_out sequence 0x02,0x04,0x08,0x10,0x20,0x40,0x80,0x1D,0x3A,0x74,0xE8,0xCD,0x87,0x13.
  - Returns to 0x01 after exactly 255 steps, never 0x00.
- Seed load:
  - seed_in=0xA5 in IDLE -> lfsr=0xA5.
  - seed_in=0x00 -> lfsr=0x01.
  - Load during RUN -> word aborted, IDLE, valid_out=0, busy_out=0.
- Synchronous reset mid-HOLD with seed_load_in=1 -> next cycle lfsr=0x01, valid_out=0, state IDLE.
  - An asynchronous reset_n_in glitch between edges has no effect.
- Parameter sweep: WIDTH=16, TAPS=16'h002D, OUT_W=16, STEPS=1, free-run -> period 65535, no zero state.
